regression_sample_buffer: RTL and testbench
===========================================

Name: regression_sample_buffer

Overview:
Parametrised dual-channel (x, y) sample store for the linear-regression datapath. Samples are written serially through one write port. A start/done handshake then streams every stored sample through a one-deep pipeline that produces the regression sums Σx, Σy, Σxy and Σx². A random-access read port allows per-sample inspection. It replaces the fixed 150×20 flat-array memory pair with a depth- and width-generic block that computes its own statistics.

Parameters:
DATA_W, 20, sample width; signed two's complement.
DEPTH, 150, maximum number of stored sample pairs.
ADDR_W, 8, address/pointer width; must satisfy 2^ADDR_W ≥ DEPTH.
ACC_W, 48, accumulator width; must satisfy ACC_W ≥ 2·DATA_W + ceil(log2 DEPTH).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous flush: empties the store, zeroes the sums, aborts any run
wr_en  in  1  write one sample pair at the write pointer
wr_x  in  DATA_W  x sample
wr_y  in  DATA_W  y sample
full  out  1  count == DEPTH
count  out  ADDR_W+1  number of stored samples
rd_addr  in  ADDR_W  random read address
rd_x  out  DATA_W  x[rd_addr], combinational
rd_y  out  DATA_W  y[rd_addr], combinational
start  in  1  begin accumulation pass
busy  out  1  pass in progress
done  out  1  one-cycle pulse: sums valid
sum_x, sum_y, sum_xy, sum_xx  out  ACC_W each  signed sums, held until the next start, clear or reset

Behaviour:
- Reset (async): count=0, state IDLE, busy=0, done=0, all sums=0. Memory contents are not cleared. rd_x/rd_y follow the memory contents.
- Write:
  - Accepted only when wr_en=1, state IDLE, full=0 and clear=0.
  - An accepted write stores at index count, then count increments.
  - A write while full or busy is silently dropped; count is unchanged.
- Read: rd_addr ≥ count returns the stale memory contents. rd_addr ≥ DEPTH returns 0.
- FSM states: IDLE, RUN, DRAIN, FINISH.
  - IDLE, start=1, count=N>0: zero the sums, index:=0, go to RUN.
  - IDLE, start=1, count=0: zero the sums, go to FINISH.
  - RUN: each cycle, register x[index] and y[index] into the pipe stage and accumulate the previous pipe stage. When index==N-1, go to DRAIN; otherwise index+1.
  - DRAIN: accumulate the last pipe stage, go to FINISH.
  - FINISH: done=1 for this cycle, then go to IDLE.
- busy=1 in RUN and DRAIN.
- Latency: with start sampled at edge 0, done is high in the cycle following edge N+1. Empty case: done is high after edge 1.
- start outside IDLE is ignored. start and wr_en together in IDLE: the write is accepted and start is ignored that cycle.
- Arithmetic:
  - Products x·y and x·x are full 2·DATA_W signed.
  - Products and x, y are sign-extended to ACC_W before adding.
  - No saturation needed; the ACC_W rule guarantees no overflow.
- clear has priority over everything except reset:
  - Sets count=0, sums=0 and state IDLE.
  - done is never pulsed for an aborted run.
- reset mid-run: immediate return to the reset values above; done is never pulsed.

Decomposition:
- Shared package regression_pkg:
  - FSM state enum (IDLE/RUN/DRAIN/FINISH).
  - Default DATA_W/DEPTH/ACC_W constants.
  - A function computing the minimum ACC_W.
- One natural sub-module: sample_mem. It is a DEPTH×DATA_W array with one synchronous write and two ports: one combinational read port and one registered read port. It is instantiated twice, for x and y.
- The FSM and accumulators stay in the top module.

Test Plan:
1. Write (1,2),(2,4),(3,6), then pulse start → sum_x=6, sum_y=12, sum_xy=28, sum_xx=14; busy for cycles 1–4; done high after edge 4 only; count=3.
2. Signed data: write (-1,3),(2,-5) → sum_x=1, sum_y=-2, sum_xy=-13, sum_xx=5; rd_addr=0 gives rd_x=-1, rd_y=3.
3. Capacity and worst case: write 151 pairs of (524287,-524288) → full=1 and count=150 after the 150th write; the 151st write is dropped. Then start → sum_xx=150·524287², sum_xy=-150·524287·524288, with no overflow.
4. Empty start: after reset, pulse start → done after edge 1; all sums=0; busy never asserted.
5. Abort: start with count=100, then assert clear at cycle 50 → busy=0 next cycle, no done ever, count=0, sums=0. The next write lands at index 0.
6. Async reset mid-run, and writes/start while busy: reset is asserted between edges → outputs reach reset values before the next edge. wr_en while busy leaves count unchanged. A second start while busy does not restart or extend the run.

Source files
------------

// File: rtl/regression_pkg.sv
// Shared types and defaults for the regression sample buffer.
// Holds the pass FSM encoding and accumulator sizing helper.
package regression_pkg;

  localparam int DATA_W_DEF = 20;
  localparam int DEPTH_DEF  = 150;
  localparam int ADDR_W_DEF = 8;
  localparam int ACC_W_DEF  = 48;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } state_t;

  // Smallest accumulator that cannot overflow summing DEPTH full-scale products.
  function automatic int min_acc_w(input int dw, input int depth);
    return 2 * dw + $clog2(depth);
  endfunction

endpackage

// File: rtl/regression_sample_buffer_sample_mem.sv
// DEPTH x DATA_W sample store: one synchronous write port,
// one combinational read port and one registered read port.
module sample_mem #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 150,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] caddr,
  output logic [DATA_W-1:0] cdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] qaddr,
  output logic [DATA_W-1:0] qdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] qdata_q;
  logic [DATA_W-1:0] qdata_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // Contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we && in_range(waddr)) begin
      mem[waddr] <= wdata;
    end
  end

  assign cdata = in_range(caddr) ? mem[caddr] : '0;

  always_comb begin
    qdata_d = qdata_q;
    if (re) begin
      qdata_d = in_range(qaddr) ? mem[qaddr] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qdata_q <= '0;
    end else begin
      qdata_q <= qdata_d;
    end
  end

  assign qdata = qdata_q;

endmodule

// File: rtl/regression_sample_buffer.sv
// Dual-channel sample store that streams its contents through a
// one-deep pipe to build the sums used by linear regression.
module regression_sample_buffer
  import regression_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_x,
  input  logic [DATA_W-1:0] wr_y,
  output logic              full,
  output logic [ADDR_W:0]   count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_x,
  output logic [DATA_W-1:0] rd_y,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sum_x,
  output logic [ACC_W-1:0]  sum_y,
  output logic [ACC_W-1:0]  sum_xy,
  output logic [ACC_W-1:0]  sum_xx
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int PW    = 2 * DATA_W;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              pv_q, pv_d;
  logic              empty_q, empty_d;
  logic [ACC_W-1:0]  sx_q, sx_d;
  logic [ACC_W-1:0]  sy_q, sy_d;
  logic [ACC_W-1:0]  sxy_q, sxy_d;
  logic [ACC_W-1:0]  sxx_q, sxx_d;

  logic              idle;
  logic              wr_ok;
  logic              mem_re;
  logic              last;
  logic [DATA_W-1:0] px, py;
  logic [PW-1:0]     xe, ye, pxy, pxx;
  logic [ACC_W-1:0]  ax, ay, axy, axx;

  assign full  = count_q == CNT_W'(DEPTH);
  // An empty pass spends one IDLE cycle pending so done keeps N+1 latency.
  assign idle  = (state_q == IDLE) && !empty_q;
  assign wr_ok = wr_en && idle && !full && !clear;
  assign last  = {1'b0, idx_q} == (count_q - CNT_W'(1));

  sample_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem_x (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok),
    .waddr (count_q[ADDR_W-1:0]),
    .wdata (wr_x),
    .caddr (rd_addr),
    .cdata (rd_x),
    .re    (mem_re),
    .qaddr (idx_q),
    .qdata (px)
  );

  sample_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem_y (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok),
    .waddr (count_q[ADDR_W-1:0]),
    .wdata (wr_y),
    .caddr (rd_addr),
    .cdata (rd_y),
    .re    (mem_re),
    .qaddr (idx_q),
    .qdata (py)
  );

  // Sign-extended operands make the low PW product bits exact.
  assign xe  = {{DATA_W{px[DATA_W-1]}}, px};
  assign ye  = {{DATA_W{py[DATA_W-1]}}, py};
  assign pxy = xe * ye;
  assign pxx = xe * xe;

  assign ax  = {{(ACC_W-DATA_W){px[DATA_W-1]}}, px};
  assign ay  = {{(ACC_W-DATA_W){py[DATA_W-1]}}, py};
  assign axy = {{(ACC_W-PW){pxy[PW-1]}}, pxy};
  assign axx = {{(ACC_W-PW){pxx[PW-1]}}, pxx};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    pv_d    = pv_q;
    empty_d = 1'b0;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sxy_d   = sxy_q;
    sxx_d   = sxx_q;
    mem_re  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (empty_q) begin
          state_d = FINISH;
        end else if (wr_ok) begin
          count_d = count_q + CNT_W'(1);
        end else if (start && !wr_en) begin
          sx_d  = '0;
          sy_d  = '0;
          sxy_d = '0;
          sxx_d = '0;
          pv_d  = 1'b0;
          idx_d = '0;
          if (count_q == '0) begin
            empty_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        mem_re = 1'b1;
        pv_d   = 1'b1;
        if (pv_q) begin
          sx_d  = sx_q + ax;
          sy_d  = sy_q + ay;
          sxy_d = sxy_q + axy;
          sxx_d = sxx_q + axx;
        end
        if (last) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (pv_q) begin
          sx_d  = sx_q + ax;
          sy_d  = sy_q + ay;
          sxy_d = sxy_q + axy;
          sxx_d = sxx_q + axx;
        end
        pv_d    = 1'b0;
        state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
    endcase

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      idx_d   = '0;
      pv_d    = 1'b0;
      empty_d = 1'b0;
      sx_d    = '0;
      sy_d    = '0;
      sxy_d   = '0;
      sxx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      pv_q    <= 1'b0;
      empty_q <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      sxy_q   <= '0;
      sxx_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      pv_q    <= pv_d;
      empty_q <= empty_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sxy_q   <= sxy_d;
      sxx_q   <= sxx_d;
    end
  end

  assign count  = count_q;
  assign busy   = (state_q == RUN) || (state_q == DRAIN);
  assign done   = state_q == FINISH;
  assign sum_x  = sx_q;
  assign sum_y  = sy_q;
  assign sum_xy = sxy_q;
  assign sum_xx = sxx_q;

endmodule

// File: tb/tb_regression_sample_buffer.sv
// Bench for regression_sample_buffer: directed scenarios plus
// randomized passes against a queue-based sum model.
module tb_regression_sample_buffer;

  localparam int DW    = 20;
  localparam int DEPTH = 150;
  localparam int AW    = 8;
  localparam int ACC   = 48;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear;
  logic            wr_en;
  logic [DW-1:0]   wr_x, wr_y;
  logic            full;
  logic [AW:0]     count;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_x, rd_y;
  logic            start;
  logic            busy;
  logic            done;
  logic [ACC-1:0]  sum_x, sum_y, sum_xy, sum_xx;

  int total = 0;
  int bad   = 0;
  int mx[$];
  int my[$];
  longint ex, ey, exy, exx;

  regression_sample_buffer #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .ACC_W  (ACC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .wr_en   (wr_en),
    .wr_x    (wr_x),
    .wr_y    (wr_y),
    .full    (full),
    .count   (count),
    .rd_addr (rd_addr),
    .rd_x    (rd_x),
    .rd_y    (rd_y),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .sum_x   (sum_x),
    .sum_y   (sum_y),
    .sum_xy  (sum_xy),
    .sum_xx  (sum_xx)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic longint sv(input logic [ACC-1:0] s);
    return longint'($signed(s));
  endfunction

  function automatic int rnd20();
    logic [19:0] r;
    r = 20'($urandom);
    return int'($signed(r));
  endfunction

  task automatic wr(input int x, input int y);
    wr_x  = DW'(x);
    wr_y  = DW'(y);
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    if (mx.size() < DEPTH) begin
      mx.push_back(x);
      my.push_back(y);
    end
  endtask

  task automatic flush;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mx.delete();
    my.delete();
  endtask

  task automatic model_sums;
    ex = 0; ey = 0; exy = 0; exx = 0;
    foreach (mx[i]) begin
      ex  += mx[i];
      ey  += my[i];
      exy += longint'(mx[i]) * my[i];
      exx += longint'(mx[i]) * mx[i];
    end
  endtask

  // Pulses start (edge 0) and watches `window` further edges.
  task automatic run_pass(input int window, output int dedge,
                          output int ndone, output int nbusy);
    start = 1'b1;
    tick();
    start = 1'b0;
    dedge = -1;
    ndone = 0;
    nbusy = 0;
    if (busy) nbusy++;
    if (done) begin ndone++; dedge = 0; end
    for (int k = 1; k <= window; k++) begin
      tick();
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (dedge < 0) dedge = k;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #13;
    total++;
    if ({count, busy, done, full} !== '0) begin
      bad++;
      $display("FAIL reset_ctl: count=%0d busy=%b done=%b full=%b want 0",
               count, busy, done, full);
    end
    total++;
    if ({sum_x, sum_y, sum_xy, sum_xx} !== '0) begin
      bad++;
      $display("FAIL reset_sums: %0d %0d %0d %0d want 0",
               sv(sum_x), sv(sum_y), sv(sum_xy), sv(sum_xx));
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_empty;
    int de, nd, nb;
    run_pass(6, de, nd, nb);
    total++;
    if (de !== 1 || nd !== 1 || nb !== 0) begin
      bad++;
      $display("FAIL empty_timing: done_edge=%0d ndone=%0d nbusy=%0d want 1 1 0",
               de, nd, nb);
    end
    total++;
    if ({sum_x, sum_y, sum_xy, sum_xx} !== '0) begin
      bad++;
      $display("FAIL empty_sums: %0d %0d %0d %0d want 0",
               sv(sum_x), sv(sum_y), sv(sum_xy), sv(sum_xx));
    end
  endtask

  task automatic test_basic;
    int de, nd, nb;
    flush();
    wr(1, 2);
    wr(2, 4);
    wr(3, 6);
    total++;
    if (count !== 9'd3) begin
      bad++;
      $display("FAIL basic_count: got %0d want 3", count);
    end
    run_pass(8, de, nd, nb);
    total++;
    if (de !== 4 || nd !== 1 || nb !== 4) begin
      bad++;
      $display("FAIL basic_timing: done_edge=%0d ndone=%0d nbusy=%0d want 4 1 4",
               de, nd, nb);
    end
    total++;
    if (sv(sum_x) !== 64'sd6 || sv(sum_y) !== 64'sd12) begin
      bad++;
      $display("FAIL basic_sxy: sx=%0d sy=%0d want 6 12", sv(sum_x), sv(sum_y));
    end
    total++;
    if (sv(sum_xy) !== 64'sd28 || sv(sum_xx) !== 64'sd14) begin
      bad++;
      $display("FAIL basic_prod: sxy=%0d sxx=%0d want 28 14",
               sv(sum_xy), sv(sum_xx));
    end
  endtask

  task automatic test_signed;
    int de, nd, nb;
    flush();
    wr(-1, 3);
    wr(2, -5);
    run_pass(6, de, nd, nb);
    model_sums();
    total++;
    if (sv(sum_x) !== ex || sv(sum_y) !== ey ||
        sv(sum_xy) !== exy || sv(sum_xx) !== exx) begin
      bad++;
      $display("FAIL signed_sums: %0d %0d %0d %0d want %0d %0d %0d %0d",
               sv(sum_x), sv(sum_y), sv(sum_xy), sv(sum_xx),
               ex, ey, exy, exx);
    end
    rd_addr = 8'd0;
    #1;
    total++;
    if (int'($signed(rd_x)) !== -1 || int'($signed(rd_y)) !== 3) begin
      bad++;
      $display("FAIL signed_read: x=%0d y=%0d want -1 3",
               $signed(rd_x), $signed(rd_y));
    end
    rd_addr = 8'd200;
    #1;
    total++;
    if (rd_x !== '0 || rd_y !== '0) begin
      bad++;
      $display("FAIL read_oob: x=%0d y=%0d want 0 0", rd_x, rd_y);
    end
  endtask

  task automatic test_capacity;
    int de, nd, nb;
    flush();
    for (int i = 0; i < 150; i++) wr(524287, -524288);
    total++;
    if (full !== 1'b1 || count !== 9'd150) begin
      bad++;
      $display("FAIL cap_full: full=%b count=%0d want 1 150", full, count);
    end
    wr(1, 1);
    total++;
    if (count !== 9'd150) begin
      bad++;
      $display("FAIL cap_drop: count=%0d want 150", count);
    end
    rd_addr = 8'd149;
    #1;
    total++;
    if (int'($signed(rd_x)) !== 524287) begin
      bad++;
      $display("FAIL cap_last: x=%0d want 524287", $signed(rd_x));
    end
    run_pass(160, de, nd, nb);
    total++;
    if (de !== 151 || nd !== 1) begin
      bad++;
      $display("FAIL cap_timing: done_edge=%0d ndone=%0d want 151 1", de, nd);
    end
    total++;
    if (sv(sum_xx) !== 64'sd150 * 524287 * 524287 ||
        sv(sum_xy) !== -64'sd150 * 524287 * 524288) begin
      bad++;
      $display("FAIL cap_sums: sxx=%0d sxy=%0d want %0d %0d",
               sv(sum_xx), sv(sum_xy),
               64'sd150 * 524287 * 524287, -64'sd150 * 524287 * 524288);
    end
  endtask

  task automatic test_abort;
    int nd;
    flush();
    for (int i = 0; i < 100; i++) wr(rnd20(), rnd20());
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 50; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mx.delete();
    my.delete();
    total++;
    if (busy !== 1'b0 || count !== '0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: busy=%b count=%0d done=%b want 0 0 0",
               busy, count, done);
    end
    total++;
    if ({sum_x, sum_y, sum_xy, sum_xx} !== '0) begin
      bad++;
      $display("FAIL abort_sums: %0d %0d %0d %0d want 0",
               sv(sum_x), sv(sum_y), sv(sum_xy), sv(sum_xx));
    end
    nd = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (done) nd++;
    end
    total++;
    if (nd !== 0) begin
      bad++;
      $display("FAIL abort_done: pulses=%0d want 0", nd);
    end
    wr(7, 8);
    rd_addr = 8'd0;
    #1;
    total++;
    if (count !== 9'd1 || int'($signed(rd_x)) !== 7 || int'($signed(rd_y)) !== 8) begin
      bad++;
      $display("FAIL abort_rewrite: count=%0d x=%0d y=%0d want 1 7 8",
               count, $signed(rd_x), $signed(rd_y));
    end
  endtask

  task automatic test_busy_and_reset;
    int de, nd;
    flush();
    for (int i = 0; i < 10; i++) wr(rnd20(), rnd20());
    model_sums();
    start = 1'b1;
    tick();
    start = 1'b0;
    de = -1;
    nd = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 2 || k == 6) begin
        wr_en = 1'b1;
        wr_x  = 20'h00055;
        wr_y  = 20'h000AA;
        start = 1'b1;
      end
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      if (done) begin
        nd++;
        if (de < 0) de = k;
      end
    end
    total++;
    if (de !== 11 || nd !== 1 || count !== 9'd10) begin
      bad++;
      $display("FAIL busy_poke: done_edge=%0d ndone=%0d count=%0d want 11 1 10",
               de, nd, count);
    end
    total++;
    if (sv(sum_x) !== ex || sv(sum_y) !== ey ||
        sv(sum_xy) !== exy || sv(sum_xx) !== exx) begin
      bad++;
      $display("FAIL busy_sums: %0d %0d %0d %0d want %0d %0d %0d %0d",
               sv(sum_x), sv(sum_y), sv(sum_xy), sv(sum_xx),
               ex, ey, exy, exx);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || count !== '0 || done !== 1'b0 ||
        {sum_x, sum_y, sum_xy, sum_xx} !== '0) begin
      bad++;
      $display("FAIL async_reset: busy=%b count=%0d done=%b sx=%0d want all 0",
               busy, count, done, sv(sum_x));
    end
    #2;
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) nd++;
    end
    rd_addr = 8'd0;
    #1;
    total++;
    if (nd !== 0 || int'($signed(rd_x)) !== mx[0]) begin
      bad++;
      $display("FAIL reset_after: done_pulses=%0d rd_x=%0d want 0 %0d",
               nd, $signed(rd_x), mx[0]);
    end
    mx.delete();
    my.delete();
  endtask

  task automatic test_random;
    int n, de, nd, nb, ia;
    for (int r = 0; r < 5; r++) begin
      flush();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) wr(rnd20(), rnd20());
      ia = $urandom_range(0, n - 1);
      rd_addr = AW'(ia);
      #1;
      total++;
      if (int'($signed(rd_x)) !== mx[ia] || int'($signed(rd_y)) !== my[ia]) begin
        bad++;
        $display("FAIL rand_read[%0d]: x=%0d y=%0d want %0d %0d",
                 ia, $signed(rd_x), $signed(rd_y), mx[ia], my[ia]);
      end
      model_sums();
      run_pass(n + 6, de, nd, nb);
      total++;
      if (de !== n + 1 || nd !== 1 || nb !== n + 1) begin
        bad++;
        $display("FAIL rand_timing n=%0d: done_edge=%0d ndone=%0d nbusy=%0d",
                 n, de, nd, nb);
      end
      total++;
      if (sv(sum_x) !== ex || sv(sum_y) !== ey ||
          sv(sum_xy) !== exy || sv(sum_xx) !== exx) begin
        bad++;
        $display("FAIL rand_sums n=%0d: %0d %0d %0d %0d want %0d %0d %0d %0d",
                 n, sv(sum_x), sv(sum_y), sv(sum_xy), sv(sum_xx),
                 ex, ey, exy, exx);
      end
    end
  endtask

  initial begin
    clear   = 1'b0;
    wr_en   = 1'b0;
    wr_x    = '0;
    wr_y    = '0;
    start   = 1'b0;
    rd_addr = '0;
    test_reset();
    test_empty();
    test_basic();
    test_signed();
    test_capacity();
    test_abort();
    test_busy_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
